dot_int_acc: RTL and testbench
==============================

# dot_int_acc

Pipelined, parametrised integer dot-product accumulator: the sequential successor to the combinational int8 dot unit. It accepts one k-lane vector pair per beat over a valid/ready handshake and accumulates a block of up to max_beats beats (block length k × beats). It emits one registered result per block and supports signed or unsigned operands, selected per block. It sits between the MX element unpack stage and the shared-scale apply stage.

## Interface
- bit_width, 8: operand element width.
- k, 4: lanes per beat.
- max_beats, 8: maximum beats per block (≥1).
- out_width, 2*bit_width + $clog2(k) + $clog2(max_beats) + 1: result width. The +1 covers the unsigned sign-free range and the signed extreme.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid && o_ready.
- i_vec_a  in  [bit_width-1:0] × k  operand A lanes.
- i_vec_b  in  [bit_width-1:0] × k  operand B lanes.
- i_last  in  1  beat is the final beat of its block.
- i_signed  in  1  operand mode. Sampled on the first beat of a block only: 1 = two's complement, 0 = unsigned.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result when o_valid && i_ready.
- o_dp  out  out_width  block dot product, interpreted per that block's mode (sign-extended when signed).
- o_trunc  out  1  block was closed by the max_beats limit, not by i_last.

## Operation
- Stage 1 (product): on acceptance, register k products plus last, trunc and mode flags, and stage-valid s1_v. Products are sign- or zero-extended per the block mode latched at the first beat.
- Stage 2 (accumulate): when s1_v, sum the k products with an adder tree to full width.
  - First beat of block: acc = sum.
  - Otherwise: acc = acc + sum.
- Block close: when the stage-1 beat is last:
  - o_dp is loaded with the final value (acc + sum, or sum for a one-beat block).
  - o_valid is set.
  - acc is cleared to 0.
  - o_trunc is loaded with the trunc flag.
- Beat counter (0..max_beats-1): counts accepted beats in the current block and returns to 0 on close.
- max_beats limit: if the accepted beat has counter == max_beats-1 and i_last == 0, it is forced to last with trunc = 1. The next accepted beat starts a new block and samples i_signed again.
- No saturation. out_width is exact for max_beats beats, so overflow cannot occur.
- Stall: stall = o_valid && !i_ready.
  - While stalled, stage 1, acc, counter and the output register all hold.
  - o_ready = !stall. This is a combinational path from i_ready, which the integrating level must accept.
- Result handshake: on o_valid && i_ready with no new close that cycle, o_valid clears. A close in the same cycle as the handshake loads the new result, so o_valid stays 1.
- Reset (any cycle, including mid-block): next edge clears s1_v, acc, counter, o_valid, o_dp, o_trunc and mode to 0. The partial block is discarded.

## Timing
- Reset values:
  - o_valid = 0, o_dp = 0, o_trunc = 0.
  - o_ready = 1 from the first cycle after reset.
- Latency: last beat accepted at edge E0 → o_valid = 1 with o_dp after edge E0+2 (2 cycles).
- Throughput: one beat per cycle with no stall. Back-to-back blocks, including one-beat blocks, run with no bubble.
- A one-beat block (i_last on first beat) produces o_dp equal to the combinational k-lane dot product.
- o_dp and o_trunc are stable while o_valid && !i_ready.
- Results leave in acceptance order. No beat is lost or duplicated across stalls.

## Test plan
- Single beat, signed: a = {1,2,3,4}, b = {5,6,7,8}, i_last = 1 → o_valid two cycles later, o_dp = 70, o_trunc = 0.
- Signed extremes: 8 beats of all lanes −128 × −128, i_last on beat 8 → o_dp = 524288, o_trunc = 0. One lane −128 × 127 with the others 0, single beat → o_dp = −16256 (sign-extended).
- Unsigned mode: i_signed = 0, all lanes 0xFF × 0xFF, single beat → o_dp = 260100. Set i_signed = 1 on beat 2 of a 2-beat unsigned block → mode is unchanged and o_dp = 520200.
- Backpressure:
  - Stream three 2-beat blocks with i_ready held low for 3 cycles while the first result is pending.
  - Expected: o_ready = 0 throughout, o_dp stable.
  - Expected: all three results correct and in order.
- max_beats limit: 9 beats of a = b = {1,1,1,1}, i_last only on beat 9 → first result o_dp = 32 with o_trunc = 1, then o_dp = 4 with o_trunc = 0.
- Reset mid-block: 2 beats accepted, then i_rst for one cycle → o_valid = 0 and o_ready = 1 the next cycle. A following single-beat block {1,1,1,1}·{2,2,2,2} gives o_dp = 8.
- Formal: for random streams, o_dp matches a reference sum of per-beat signed or unsigned products over each block.

Source files
------------

// File: rtl/dot_int_acc.sv
// Pipelined k-lane integer dot-product accumulator with valid/ready on both sides.
// Each block of up to max_beats beats yields one result. Operand signedness is chosen per block.
module dot_int_acc #(
    parameter int bit_width = 8,
    parameter int k         = 4,
    parameter int max_beats = 8,
    parameter int out_width = 2*bit_width + $clog2(k) + $clog2(max_beats) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [k*bit_width-1:0]   i_vec_a,
    input  logic [k*bit_width-1:0]   i_vec_b,
    input  logic                     i_last,
    input  logic                     i_signed,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [out_width-1:0]     o_dp,
    output logic                     o_trunc
);

    localparam int pw = 2*bit_width + 2;
    localparam int cw = (max_beats > 1) ? $clog2(max_beats) : 1;
    localparam logic [cw-1:0] last_cnt = cw'(max_beats - 1);

    logic                    stall;
    logic                    accept;
    logic                    first_beat;
    logic                    mode_eff;
    logic                    close_in;
    logic                    trunc_in;
    logic [cw-1:0]           cnt;
    logic                    mode;

    logic signed [pw-1:0]    prod_d [k];
    logic signed [bit_width:0]   ea;
    logic signed [bit_width:0]   eb;
    logic [bit_width-1:0]    a_lane;
    logic [bit_width-1:0]    b_lane;

    logic                    s1_v;
    logic                    s1_last;
    logic                    s1_trunc;
    logic                    s1_first;
    logic signed [pw-1:0]    s1_prod [k];

    logic signed [out_width-1:0] sum_d;
    logic                    s2_v;
    logic                    s2_last;
    logic                    s2_trunc;
    logic                    s2_first;
    logic signed [out_width-1:0] s2_sum;

    logic signed [out_width-1:0] acc;
    logic signed [out_width-1:0] acc_sum;

    assign stall      = o_valid && !i_ready;
    assign o_ready    = !stall;
    assign accept     = i_valid && o_ready;
    assign first_beat = (cnt == '0);
    // Mode is taken live on a block's first beat, latched for the rest of it.
    assign mode_eff   = first_beat ? i_signed : mode;
    assign trunc_in   = (cnt == last_cnt) && !i_last;
    assign close_in   = i_last || (cnt == last_cnt);

    // Extending each lane by one bit (sign or zero) lets one signed multiplier serve both modes.
    always_comb begin
        ea     = '0;
        eb     = '0;
        a_lane = '0;
        b_lane = '0;
        for (int unsigned i = 0; i < k; i++) begin
            a_lane    = i_vec_a[i*bit_width +: bit_width];
            b_lane    = i_vec_b[i*bit_width +: bit_width];
            ea        = {mode_eff & a_lane[bit_width-1], a_lane};
            eb        = {mode_eff & b_lane[bit_width-1], b_lane};
            prod_d[i] = ea * eb;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < k; i++) begin
            sum_d = sum_d + out_width'(s1_prod[i]);
        end
    end

    assign acc_sum = s2_first ? s2_sum : acc + s2_sum;

    // The lane sum is registered before accumulation, so a closing beat shows up two edges after acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt      <= '0;
            mode     <= 1'b0;
            s1_v     <= 1'b0;
            s1_last  <= 1'b0;
            s1_trunc <= 1'b0;
            s1_first <= 1'b0;
            for (int unsigned i = 0; i < k; i++) begin
                s1_prod[i] <= '0;
            end
            s2_v     <= 1'b0;
            s2_last  <= 1'b0;
            s2_trunc <= 1'b0;
            s2_first <= 1'b0;
            s2_sum   <= '0;
            acc      <= '0;
            o_valid  <= 1'b0;
            o_dp     <= '0;
            o_trunc  <= 1'b0;
        end else if (!stall) begin
            s1_v <= accept;
            if (accept) begin
                s1_prod  <= prod_d;
                s1_last  <= close_in;
                s1_trunc <= trunc_in;
                s1_first <= first_beat;
                cnt      <= close_in ? '0 : cnt + 1'b1;
                if (first_beat) begin
                    mode <= i_signed;
                end
            end

            s2_v     <= s1_v;
            s2_sum   <= sum_d;
            s2_last  <= s1_last;
            s2_trunc <= s1_trunc;
            s2_first <= s1_first;

            // Not stalled means any pending result is being taken now, so o_valid depends only on a new close.
            o_valid <= s2_v && s2_last;
            if (s2_v) begin
                if (s2_last) begin
                    o_dp    <= acc_sum;
                    o_trunc <= s2_trunc;
                    acc     <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_int_acc.sv
// Scoreboard bench for dot_int_acc: expected block results are queued at beat acceptance
// and compared when each result is handed off downstream.
module tb_dot_int_acc;

    localparam int BW = 8;
    localparam int K  = 4;
    localparam int MB = 8;
    localparam int OW = 2*BW + $clog2(K) + $clog2(MB) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic [K*BW-1:0]   vec_a;
    logic [K*BW-1:0]   vec_b;
    logic              i_last;
    logic              i_signed;
    logic              o_valid;
    logic              i_ready;
    logic [OW-1:0]     o_dp;
    logic              o_trunc;

    typedef struct {
        longint dp;
        bit     trunc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_fail   = 0;

    int     m_cnt = 0;
    bit     m_mode = 1'b0;
    longint m_acc = 0;
    bit     m_push_en = 1'b0;
    bit     rnd_done = 1'b0;

    dot_int_acc #(
        .bit_width (BW),
        .k         (K),
        .max_beats (MB)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_vec_a  (vec_a),
        .i_vec_b  (vec_b),
        .i_last   (i_last),
        .i_signed (i_signed),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_dp     (o_dp),
        .o_trunc  (o_trunc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input longint dp, input bit trunc);
        exp_t e;
        e.dp    = dp;
        e.trunc = trunc;
        exp_q.push_back(e);
    endtask

    // Reference: per-beat dot product under the block's mode, summed over the block.
    task automatic model_beat(input logic [K*BW-1:0] a, input logic [K*BW-1:0] b,
                              input bit last, input bit sgn);
        logic [BW-1:0] av;
        logic [BW-1:0] bv;
        if (m_cnt == 0) m_mode = sgn;
        for (int l = 0; l < K; l++) begin
            av = a[l*BW +: BW];
            bv = b[l*BW +: BW];
            if (m_mode) m_acc += longint'($signed(av)) * longint'($signed(bv));
            else        m_acc += longint'(av) * longint'(bv);
        end
        if (last || m_cnt == MB-1) begin
            if (m_push_en) push_exp(m_acc, !last);
            m_acc = 0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic send_beat(input logic [K*BW-1:0] a, input logic [K*BW-1:0] b,
                             input bit last, input bit sgn);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        vec_a    = a;
        vec_b    = b;
        i_last   = last;
        i_signed = sgn;
        i_valid  = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
            n++;
        end
        if (!ok) check_val("accept_timeout", 0, 1);
        else     model_beat(a, b, last, sgn);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_result", longint'($signed(o_dp)), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("dp", longint'($signed(o_dp)), mon_e.dp);
                check_val("trunc", longint'(o_trunc), longint'(mon_e.trunc));
            end
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        i_valid  = 1'b0;
        vec_a    = '0;
        vec_b    = '0;
        i_last   = 1'b0;
        i_signed = 1'b0;
        i_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_val("rst_o_valid", longint'(o_valid), 0);
        check_val("rst_o_dp", longint'(o_dp), 0);
        check_val("rst_o_trunc", longint'(o_trunc), 0);
        check_val("rst_o_ready", longint'(o_ready), 1);
        @(posedge clk);
        #1;

        // Single signed beat and its two-edge latency.
        push_exp(70, 1'b0);
        send_beat(32'h04030201, 32'h08070605, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_val("latency_e1_o_valid", longint'(o_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check_val("latency_e2_o_valid", longint'(o_valid), 1);
        drain();

        // Signed extremes.
        push_exp(524288, 1'b0);
        for (int i = 0; i < 8; i++) send_beat(32'h80808080, 32'h80808080, i == 7, 1'b1);
        push_exp(-16256, 1'b0);
        send_beat(32'h00000080, 32'h0000007F, 1'b1, 1'b1);
        drain();

        // Unsigned, and i_signed ignored after the first beat.
        push_exp(260100, 1'b0);
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        push_exp(520200, 1'b0);
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        drain();

        // Backpressure over three 2-beat blocks.
        i_ready = 1'b0;
        push_exp(16, 1'b0);
        push_exp(-24, 1'b0);
        push_exp(2048, 1'b0);
        fork
            begin
                send_beat(32'h01010101, 32'h02020202, 1'b0, 1'b1);
                send_beat(32'h01010101, 32'h02020202, 1'b1, 1'b1);
                send_beat(32'h03030303, 32'hFFFFFFFF, 1'b0, 1'b1);
                send_beat(32'h03030303, 32'hFFFFFFFF, 1'b1, 1'b1);
                send_beat(32'h10101010, 32'h10101010, 1'b0, 1'b0);
                send_beat(32'h10101010, 32'h10101010, 1'b1, 1'b0);
            end
            begin
                n = 0;
                while (!o_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (!o_valid) check_val("bp_wait_valid_timeout", 0, 1);
                repeat (3) begin
                    @(negedge clk);
                    check_val("bp_o_ready", longint'(o_ready), 0);
                    check_val("bp_o_valid", longint'(o_valid), 1);
                    check_val("bp_o_dp_hold", longint'($signed(o_dp)), exp_q[0].dp);
                end
                @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        drain();

        // max_beats forces a close on the 8th beat.
        push_exp(32, 1'b1);
        push_exp(4, 1'b0);
        for (int i = 0; i < 9; i++) send_beat(32'h01010101, 32'h01010101, i == 8, 1'b1);
        drain();

        // Reset in the middle of a block discards it.
        send_beat(32'h01010101, 32'h01010101, 1'b0, 1'b1);
        send_beat(32'h01010101, 32'h01010101, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_cnt = 0;
        m_acc = 0;
        @(negedge clk);
        check_val("midrst_o_valid", longint'(o_valid), 0);
        check_val("midrst_o_ready", longint'(o_ready), 1);
        @(posedge clk);
        #1;
        push_exp(8, 1'b0);
        send_beat(32'h01010101, 32'h02020202, 1'b1, 1'b1);
        drain();

        // Random streams against the reference model with random downstream stalls.
        m_push_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send_beat($urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        send_beat(32'h01010101, 32'h01010101, 1'b1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
